// File: rtl/mix_resp_misr.sv
// Response compactor: folds a programmed number of accepted response patterns
// into a Galois-style MISR and holds the final signature until the next start.
module mix_resp_misr #(
  parameter int unsigned       WIDTH        = 18,
  parameter int unsigned       NUM_PATTERNS = 16,
  parameter logic [WIDTH-1:0]  POLY         = 18'h00081,
  parameter logic [WIDTH-1:0]  SEED         = 18'h00000,
  localparam int unsigned      CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] resp,
  input  logic             resp_valid,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_fold;

  assign w_accept = (r_state == S_RUN) && resp_valid;
  assign w_last   = (r_count == CW'(NUM_PATTERNS - 1));

  // Shift left, fold the outgoing MSB back through the tap mask, then mix in the pattern.
  assign w_fold = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ resp;

  always_comb begin
    w_state_next = r_state;
    w_sig_next   = r_sig;
    w_count_next = r_count;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_sig_next   = SEED;
          w_count_next = '0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          w_sig_next   = w_fold;
          w_count_next = r_count + CW'(1);
          if (w_last) begin
            w_state_next = S_DONE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_sig   <= w_sig_next;
      r_count <= w_count_next;
    end
  end

  // Handshake and status are pure decodes of the registered state.
  assign resp_ready = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign signature  = r_sig;
  assign count      = r_count;

endmodule

// File: tb/tb_mix_resp_misr.sv
// Bench for mix_resp_misr: table-driven 16-pattern runs with a scoreboard on the
// main instance, plus short hand sequences on small NUM_PATTERNS/SEED variants.
module tb_mix_resp_misr;

  localparam int W    = 18;
  localparam int NP   = 16;
  localparam int CW   = $clog2(NP + 1);
  localparam logic [W-1:0] POLY = 18'h00081;
  localparam logic [W-1:0] SEED = 18'h00000;

  typedef struct {
    logic [W-1:0] resp;
    logic         valid;
    int           exp_count;
    logic         exp_done;
  } vec_t;

  typedef struct {
    logic [W-1:0] sig;
    int           cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_m, valid_m, ready_m, busy_m, done_m;
  logic [W-1:0]  resp_m, sig_m;
  logic [CW-1:0] count_m;

  logic          start_bc, start_d, valid_s;
  logic [W-1:0]  resp_s;
  logic          ready_b, busy_b, done_b, ready_c, busy_c, done_c, ready_d, busy_d, done_d;
  logic [W-1:0]  sig_b, sig_c, sig_d;
  logic [0:0]    cnt_b, cnt_d;
  logic [1:0]    cnt_c;

  mix_resp_misr #(.WIDTH(W), .NUM_PATTERNS(NP), .POLY(POLY), .SEED(SEED)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .resp(resp_m), .resp_valid(valid_m),
    .resp_ready(ready_m), .busy(busy_m), .done(done_m), .signature(sig_m), .count(count_m)
  );

  mix_resp_misr #(.WIDTH(W), .NUM_PATTERNS(1), .POLY(POLY), .SEED(18'h00000)) u_np1 (
    .clk(clk), .rst(rst), .start(start_bc), .resp(resp_s), .resp_valid(valid_s),
    .resp_ready(ready_b), .busy(busy_b), .done(done_b), .signature(sig_b), .count(cnt_b)
  );

  mix_resp_misr #(.WIDTH(W), .NUM_PATTERNS(2), .POLY(POLY), .SEED(18'h00000)) u_np2 (
    .clk(clk), .rst(rst), .start(start_bc), .resp(resp_s), .resp_valid(valid_s),
    .resp_ready(ready_c), .busy(busy_c), .done(done_c), .signature(sig_c), .count(cnt_c)
  );

  mix_resp_misr #(.WIDTH(W), .NUM_PATTERNS(1), .POLY(POLY), .SEED(18'h20000)) u_seed (
    .clk(clk), .rst(rst), .start(start_d), .resp(resp_s), .resp_valid(valid_s),
    .resp_ready(ready_d), .busy(busy_d), .done(done_d), .signature(sig_d), .count(cnt_d)
  );

  int           n_vec = 0;
  int           n_err = 0;
  exp_t         sb[$];
  logic [W-1:0] m_sig;
  int           m_cnt;
  logic         m_run, m_done;
  vec_t         tbl[NP];
  logic [W-1:0] golden;
  logic [W-1:0] pats[NP] = '{18'h00001, 18'h3FFFF, 18'h20000, 18'h15555,
                             18'h2AAAA, 18'h0F0F0, 18'h30303, 18'h12345,
                             18'h3ABCD, 18'h00080, 18'h1FFFF, 18'h0C0C0,
                             18'h21212, 18'h3C3C3, 18'h05A5A, 18'h00000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sig  = SEED;
    m_cnt  = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus on the main instance; the model predicts acceptance itself.
  task automatic beat(input logic v, input logic [W-1:0] r, input logic st);
    logic acc;
    exp_t e;
    start_m = st;
    valid_m = v;
    resp_m  = r;
    acc = v && m_run;
    if (acc) begin
      m_sig = {m_sig[W-2:0], 1'b0} ^ (m_sig[W-1] ? POLY : '0) ^ r;
      m_cnt++;
      sb.push_back('{sig: m_sig, cnt: m_cnt});
      if (m_cnt == NP) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else if (st && !m_run) begin
      m_sig  = SEED;
      m_cnt  = 0;
      m_run  = 1'b1;
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
    start_m = 1'b0;
    valid_m = 1'b0;
    if (acc) begin
      e = sb.pop_front();
      check("sb_sig", 32'(sig_m), 32'(e.sig));
      check("sb_count", 32'(count_m), 32'(e.cnt));
    end else begin
      check("hold_sig", 32'(sig_m), 32'(m_sig));
      check("hold_count", 32'(count_m), 32'(m_cnt));
    end
    check("busy", 32'(busy_m), 32'(m_run));
    check("ready", 32'(ready_m), 32'(m_run));
    check("done", 32'(done_m), 32'(m_done));
    $display("beat t=%0t start=%b valid=%b resp=%h acc=%b sig=%h count=%0d done=%b",
             $time, st, v, r, acc, sig_m, count_m, done_m);
  endtask

  task automatic run_table(input bit gaps, input int start_at);
    for (int i = 0; i < NP; i++) begin
      if (gaps) beat(1'b0, 18'h3FFFF, (i == start_at));
      beat(tbl[i].valid, tbl[i].resp, 1'b0);
      check("tbl_count", 32'(count_m), 32'(tbl[i].exp_count));
      check("tbl_done", 32'(done_m), 32'(tbl[i].exp_done));
    end
  endtask

  task automatic small_tick();
    @(posedge clk);
    #1;
    start_bc = 1'b0;
    start_d  = 1'b0;
    valid_s  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_m = 1'b0; valid_m = 1'b0; resp_m = '0;
    start_bc = 1'b0; start_d = 1'b0; valid_s = 1'b0; resp_s = '0;
    for (int i = 0; i < NP; i++) begin
      tbl[i] = '{resp: pats[i], valid: 1'b1, exp_count: i + 1, exp_done: (i == NP - 1)};
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    check("rst_sig", 32'(sig_m), 32'(SEED));
    check("rst_count", 32'(count_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_ready", 32'(ready_m), 32'd0);
    check("rst_seed_sig", 32'(sig_d), 32'h20000);

    // Valid data while idle must be dropped; then a clean gap-free run sets the golden value.
    beat(1'b1, 18'h01234, 1'b0);
    beat(1'b0, 18'h00000, 1'b1);
    run_table(1'b0, -1);
    golden = m_sig;

    // Frozen in DONE, then restart from DONE.
    beat(1'b1, 18'h00055, 1'b0);
    beat(1'b0, 18'h00000, 1'b1);
    check("restart_count", 32'(count_m), 32'd0);
    check("restart_done", 32'(done_m), 32'd0);
    check("restart_busy", 32'(busy_m), 32'd1);
    check("restart_sig", 32'(sig_m), 32'(SEED));

    // Gapped run with an ignored mid-run start must reproduce the golden signature.
    run_table(1'b1, 7);
    check("gap_golden", 32'(sig_m), 32'(golden));

    // Abort after 5 accepts; rst coincides with start and must win.
    beat(1'b0, 18'h00000, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, pats[i], 1'b0);
    check("pre_abort_count", 32'(count_m), 32'd5);
    rst = 1'b1;
    start_m = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_m = 1'b0;
    model_reset();
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_count", 32'(count_m), 32'd0);
    check("abort_sig", 32'(sig_m), 32'(SEED));
    check("abort_ready", 32'(ready_m), 32'd0);
    beat(1'b0, 18'h00000, 1'b1);
    run_table(1'b0, -1);
    check("post_abort_golden", 32'(sig_m), 32'(golden));

    // Small variants: NUM_PATTERNS=1, NUM_PATTERNS=2 and SEED=20000.
    start_bc = 1'b1;
    small_tick();
    check("np1_busy", 32'(busy_b), 32'd1);
    check("np2_busy", 32'(busy_c), 32'd1);
    check("seed_idle_ready", 32'(ready_d), 32'd0);
    valid_s = 1'b1; resp_s = 18'h00001;
    small_tick();
    check("np1_sig", 32'(sig_b), 32'h00001);
    check("np1_done", 32'(done_b), 32'd1);
    check("np1_count", 32'(cnt_b), 32'd1);
    check("np2_mid_sig", 32'(sig_c), 32'h00001);
    check("np2_mid_done", 32'(done_c), 32'd0);
    valid_s = 1'b1; resp_s = 18'h00000;
    small_tick();
    check("np2_sig", 32'(sig_c), 32'h00002);
    check("np2_done", 32'(done_c), 32'd1);
    check("np1_frozen", 32'(sig_b), 32'h00001);
    start_d = 1'b1;
    small_tick();
    check("seed_start_sig", 32'(sig_d), 32'h20000);
    valid_s = 1'b1; resp_s = 18'h00000;
    small_tick();
    check("seed_sig", 32'(sig_d), 32'h00081);
    check("seed_done", 32'(done_d), 32'd1);
    $display("small variants t=%0t np1=%h np2=%h seed=%h", $time, sig_b, sig_c, sig_d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
